fmeas_readout_ctrl: RTL

- Parametrised successor to the single-shot, fixed-width counter readout.
- Sequences frequency measurements for NUM_CH ring-oscillator counters: clears the counters, opens a programmable gate window, and lets them settle.
- Snapshots all channels coherently, then serialises each enabled channel as a framed, channel-tagged word, both raw and Manchester-coded.
- Supports single-shot and continuous modes; sits between the fmeasurment counter instances and the uo_out pins.

---
 rtl/fmeas_readout_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fmeas_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fmeas_readout_ctrl
// Description : Sequences NUM_CH ring-oscillator frequency measurements
//               (clear, gate, settle, snapshot). Each enabled channel is then
//               sent as a framed, channel-tagged serial word, raw and
//               Manchester-coded.
//               Optional macro FMEAS_PARITY_EN appends an even-parity bit,
//               computed over the count bits, to each channel frame.
// Revision    : 1.0 - initial release
// ============================================================================
module fmeas_readout_ctrl #(
    parameter int         NUM_CH = 4,
    parameter int         CNT_W  = 20,
    parameter int         GATE_W = 16,
    parameter int         SETTLE = 4,
    parameter logic [3:0] HDR    = 4'b1010
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    start,
    input  logic                    cont,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [GATE_W-1:0]       gate_cycles,
    input  logic [NUM_CH*CNT_W-1:0] cnt_in,
    output logic                    ctr_rst_o,
    output logic                    gate_o,
    output logic                    ser_bit,
    output logic                    ser_valid,
    output logic                    mch_out,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int C_ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef FMEAS_PARITY_EN
    localparam int C_PAR_W = 1;
`else
    localparam int C_PAR_W = 0;
`endif
    localparam int C_L     = 4 + C_ID_W + CNT_W + C_PAR_W;
    localparam int C_BIT_W = $clog2(C_L);
    localparam int C_SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int C_TMR_W = (GATE_W > C_SET_W) ? GATE_W : C_SET_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_GATE   = 3'd2,
        S_SETTLE = 3'd3,
        S_SNAP   = 3'd4,
        S_SEND   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_sync1;
    logic                       r_sync2;
    logic                       r_sync3;
    logic [C_TMR_W-1:0]         r_tmr;
    logic [C_BIT_W-1:0]         r_bit;
    logic [C_ID_W-1:0]          r_ch;
    logic [NUM_CH-1:0]          r_mask;
    logic [NUM_CH*CNT_W-1:0]    r_snap;
    logic [C_L-1:0]             r_shift;

    logic                       w_start_rise;
    logic                       w_first_found;
    logic [C_ID_W-1:0]          w_first_ch;
    logic                       w_nxt_found;
    logic [C_ID_W-1:0]          w_nxt_ch;
    logic [CNT_W-1:0]           w_first_val;
    logic [CNT_W-1:0]           w_nxt_val;
    logic [C_TMR_W-1:0]         w_gate_load;

    function automatic logic [C_L-1:0] f_frame(input logic [C_ID_W-1:0] id,
                                               input logic [CNT_W-1:0]  val);
`ifdef FMEAS_PARITY_EN
        return {HDR, id, val, ^val};
`else
        return {HDR, id, val};
`endif
    endfunction

    assign w_start_rise = r_sync2 & ~r_sync3;
    assign w_gate_load  = (gate_cycles == '0) ? '0 : C_TMR_W'(gate_cycles - 1'b1);
    assign w_first_val  = cnt_in[int'(w_first_ch)*CNT_W +: CNT_W];
    assign w_nxt_val    = r_snap[int'(w_nxt_ch)*CNT_W +: CNT_W];

    // Descending scan so the lowest qualifying index is the one that sticks.
    always_comb begin
        w_first_found = 1'b0;
        w_first_ch    = '0;
        w_nxt_found   = 1'b0;
        w_nxt_ch      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                w_first_found = 1'b1;
                w_first_ch    = C_ID_W'(i);
            end
            if (r_mask[i] && (i > int'(r_ch))) begin
                w_nxt_found = 1'b1;
                w_nxt_ch    = C_ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        ctr_rst_o  = 1'b0;
        gate_o     = 1'b0;
        ser_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   if (w_start_rise) w_next = S_CLEAR;
            S_CLEAR: begin
                ctr_rst_o = 1'b1;
                if (r_tmr == '0) w_next = S_GATE;
            end
            S_GATE: begin
                gate_o = 1'b1;
                if (r_tmr == '0) w_next = S_SETTLE;
            end
            S_SETTLE: if (r_tmr == '0) w_next = S_SNAP;
            S_SNAP:   w_next = w_first_found ? S_SEND : S_DONE;
            S_SEND: begin
                ser_valid = 1'b1;
                if ((r_bit == '0) && !w_nxt_found) w_next = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                w_next     = cont ? S_CLEAR : S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_tmr   <= '0;
            r_bit   <= '0;
            r_ch    <= '0;
            r_mask  <= '0;
            r_snap  <= '0;
            r_shift <= '0;
        end else if (ena) begin
            r_sync1 <= start;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            // Phase timer reloads on every state change, counts down to zero otherwise.
            if (w_next != r_state) begin
                case (w_next)
                    S_CLEAR:  r_tmr <= C_TMR_W'(1);
                    S_GATE:   r_tmr <= w_gate_load;
                    S_SETTLE: r_tmr <= C_TMR_W'(SETTLE - 1);
                    default:  r_tmr <= '0;
                endcase
            end else if (r_tmr != '0) begin
                r_tmr <= r_tmr - 1'b1;
            end

            if (r_state == S_SNAP) begin
                r_snap  <= cnt_in;
                r_mask  <= ch_mask;
                r_ch    <= w_first_ch;
                r_bit   <= C_BIT_W'(C_L - 1);
                r_shift <= w_first_found ? f_frame(w_first_ch, w_first_val) : '0;
            end else if (r_state == S_SEND) begin
                if (r_bit == '0) begin
                    if (w_nxt_found) begin
                        r_ch    <= w_nxt_ch;
                        r_bit   <= C_BIT_W'(C_L - 1);
                        r_shift <= f_frame(w_nxt_ch, w_nxt_val);
                    end else begin
                        r_shift <= '0;
                    end
                end else begin
                    r_bit   <= r_bit - 1'b1;
                    r_shift <= r_shift << 1;
                end
            end
        end
    end

    assign ser_bit = r_shift[C_L-1];
    assign mch_out = ser_valid & (ser_bit ^ clk);

endmodule
`default_nettype wire
